// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   number_of_bits() : frame length (start + data + parity + stop)
//   rx_state_e       : state encodings of the Rx FSM fed by rx_sample_ctrl
//   IDLE/START_VERIFY/FRAME, sample_state_e : rx_sample_ctrl state encodings
package uart_pkg;

  function automatic int number_of_bits(input int data_width);
    return data_width + 3;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] START_VERIFY = 2'd1;
  localparam logic [1:0] FRAME        = 2'd2;

  typedef enum logic [1:0] {
    SC_IDLE         = IDLE,
    SC_START_VERIFY = START_VERIFY,
    SC_FRAME        = FRAME
  } sample_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the raw Rx line plus one delay flop for
// falling-edge detection. All flops reset to the idle level (1).
//   clk, reset  : clock, asynchronous active-high reset
//   serial_i    : raw asynchronous line
//   line_s_o    : synchronised line
//   fall_o      : previous synchronised value 1, current 0
module rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic serial_i,
  output logic line_s_o,
  output logic fall_o
);

  logic meta_q;
  logic line_s_q;
  logic line_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b1;
      line_s_q <= 1'b1;
      line_d_q <= 1'b1;
    end else begin
      meta_q   <= serial_i;
      line_s_q <= meta_q;
      line_d_q <= line_s_q;
    end
  end

  assign line_s_o = line_s_q;
  assign fall_o   = line_d_q & ~line_s_q;

endmodule

// File: rtl/rx_sample_ctrl.sv
// UART receive sampling controller. Qualifies the start-bit falling edge,
// verifies it at half a bit period, then strobes at the centre of every bit.
//   clk, reset      : clock, asynchronous active-high reset
//   serial_in       : raw Rx line (idle 1)
//   enable          : receiver enable; loss mid-frame aborts the frame
//   start_detected  : pulse on accepted falling edge
//   sampling_strobe : pulse at each bit centre
//   sampled_bit     : line value captured with each strobe (held)
//   rx_abort        : pulse on false start or enable loss mid-frame
//   framing_error   : pulse with the stop-bit strobe when stop = 0
//   frame_busy      : start_detected through the final strobe
//   dbg_state       : current FSM state
// All outputs are registered.
//
// Handshake: there is no backpressure; every output is a single-cycle pulse
// (except sampled_bit, frame_busy, dbg_state) that the Rx FSM must consume
// in the cycle it is high.
module rx_sample_ctrl
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLOCKS_PER_BIT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       enable,
  output logic       start_detected,
  output logic       sampling_strobe,
  output logic       sampled_bit,
  output logic       rx_abort,
  output logic       framing_error,
  output logic       frame_busy,
  output logic [1:0] dbg_state
);

  localparam int HALF_BIT = CLOCKS_PER_BIT / 2;
  localparam int NUMBER_OF_BITS = number_of_bits(INPUT_DATA_WIDTH);
  localparam int TW  = $clog2(CLOCKS_PER_BIT);
  localparam int BCW = $clog2(NUMBER_OF_BITS);

  // The strobe register is set on the edge after the counter shows these
  // values, so compare against (period - 1).
  localparam logic [TW-1:0]  TICK_HALF = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0]  TICK_FULL = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(NUMBER_OF_BITS - 1);

  logic line_s;
  logic fall;

  rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .serial_i (serial_in),
    .line_s_o (line_s),
    .fall_o   (fall)
  );

  sample_state_e  state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic start_q, start_d;
  logic strobe_q, strobe_d;
  logic sbit_q, sbit_d;
  logic abort_q, abort_d;
  logic ferr_q, ferr_d;
  logic busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SC_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      start_q   <= 1'b0;
      strobe_q  <= 1'b0;
      sbit_q    <= 1'b1;
      abort_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      start_q   <= start_d;
      strobe_q  <= strobe_d;
      sbit_q    <= sbit_d;
      abort_q   <= abort_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    start_d   = 1'b0;
    strobe_d  = 1'b0;
    sbit_d    = sbit_q;
    abort_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      SC_IDLE: begin
        tick_d    = '0;
        bit_cnt_d = '0;
        if (fall && enable) begin
          state_d = SC_START_VERIFY;
          start_d = 1'b1;
          // Loaded with 1 so the verify strobe lands HALF_BIT edges after
          // the edge-detect cycle.
          tick_d  = TW'(1);
        end
      end

      SC_START_VERIFY: begin
        if (!enable) begin
          abort_d = 1'b1;
          state_d = SC_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_HALF) begin
          tick_d = '0;
          if (!line_s) begin
            strobe_d  = 1'b1;
            sbit_d    = line_s;
            bit_cnt_d = BCW'(1);
            state_d   = SC_FRAME;
          end else begin
            abort_d = 1'b1;
            state_d = SC_IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      SC_FRAME: begin
        if (!enable) begin
          abort_d   = 1'b1;
          state_d   = SC_IDLE;
          tick_d    = '0;
          bit_cnt_d = '0;
        end else if (tick_q == TICK_FULL) begin
          tick_d   = '0;
          strobe_d = 1'b1;
          sbit_d   = line_s;
          if (bit_cnt_q == LAST_BIT) begin
            ferr_d    = ~line_s;
            state_d   = SC_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        state_d   = SC_IDLE;
        tick_d    = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Including the strobe keeps busy high through the final strobe cycle
    // even though the state has already returned to IDLE.
    busy_d = (state_d != SC_IDLE) || strobe_d;
  end

  assign start_detected  = start_q;
  assign sampling_strobe = strobe_q;
  assign sampled_bit     = sbit_q;
  assign rx_abort        = abort_q;
  assign framing_error   = ferr_q;
  assign frame_busy      = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rx_sample_ctrl.sv
// Directed bench for rx_sample_ctrl with default parameters (16 clocks/bit,
// 8 data bits). A monitor logs every output event with its cycle number;
// the main sequence compares the log against hand-computed frames.
// Frame vectors are 11 bits, bit k = k-th bit on the line (start first).
//   0x55 -> 11'h4AA   0xA3 -> 11'h546   0x0F -> 11'h41E
//   0x3C with stop=0 -> 11'h078
module tb_rx_sample_ctrl;

  localparam int CPB = 16;
  localparam int NB  = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       enable;
  logic       start_detected;
  logic       sampling_strobe;
  logic       sampled_bit;
  logic       rx_abort;
  logic       framing_error;
  logic       frame_busy;
  logic [1:0] dbg_state;

  rx_sample_ctrl #(
    .INPUT_DATA_WIDTH (8),
    .CLOCKS_PER_BIT   (CPB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .serial_in       (serial_in),
    .enable          (enable),
    .start_detected  (start_detected),
    .sampling_strobe (sampling_strobe),
    .sampled_bit     (sampled_bit),
    .rx_abort        (rx_abort),
    .framing_error   (framing_error),
    .frame_busy      (frame_busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- event monitor ----------------
  int   start_q[$];
  int   strobe_cyc_q[$];
  logic [0:0] strobe_bit_q[$];
  int   abort_q[$];
  int   ferr_q[$];
  int   busy_fall_q[$];
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (start_detected) start_q.push_back(cyc);
    if (sampling_strobe) begin
      strobe_cyc_q.push_back(cyc);
      strobe_bit_q.push_back(sampled_bit);
    end
    if (rx_abort) abort_q.push_back(cyc);
    if (framing_error) ferr_q.push_back(cyc);
    if (busy_prev && !frame_busy) busy_fall_q.push_back(cyc);
    busy_prev = frame_busy;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int b_start, b_strobe, b_abort, b_ferr, b_fall;

  task automatic mark();
    b_start  = start_q.size();
    b_strobe = strobe_cyc_q.size();
    b_abort  = abort_q.size();
    b_ferr   = ferr_q.size();
    b_fall   = busy_fall_q.size();
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // Strobe k of a frame whose line fell right after cycle t0 is seen at
  // t0 + 2 (synchroniser) + 8 (half bit) + 16k.
  task automatic check_frame(input string tag, input int first, input int t0,
                             input logic [NB-1:0] f);
    logic [0:0] exp_q[$];
    for (int k = 0; k < NB; k++) exp_q.push_back(f[k]);
    for (int k = 0; k < NB; k++) begin
      int idx;
      logic [0:0] got;
      idx = first + k;
      got = (idx < strobe_bit_q.size()) ? strobe_bit_q[idx] : 1'bx;
      check_eq({tag, "_cyc"}, q_at(strobe_cyc_q, idx), t0 + 10 + 16 * k);
      check_eq({tag, "_bit"}, {31'd0, got}, {31'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives frame f bit by bit from a negedge. drop_at / rst_at are cycle
  // numbers relative to cycle 0 (two edges after the line falls); -1 = none.
  task automatic send_frame(input logic [NB-1:0] f, input int drop_at,
                            input int rst_at, output int t0);
    t0 = cyc;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < CPB; j++) begin
        int i;
        i = k * CPB + j;
        if (drop_at >= 0 && i == drop_at + 1) enable = 1'b0;
        if (rst_at >= 0 && i == rst_at + 1) begin
          serial_in = 1'b1;
          reset = 1'b1;
          return;
        end
        serial_in = f[k];
        @(negedge clk);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    int t0, t1;
    reset = 1'b1;
    serial_in = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("rst_start",  start_detected,  0);
    check_eq("rst_strobe", sampling_strobe, 0);
    check_eq("rst_sbit",   sampled_bit,     1);
    check_eq("rst_abort",  rx_abort,        0);
    check_eq("rst_ferr",   framing_error,   0);
    check_eq("rst_busy",   frame_busy,      0);
    check_eq("rst_state",  dbg_state,       0);
    reset = 1'b0;
    idle(5);

    // Good frame 0x55, even parity
    mark();
    send_frame(11'h4AA, -1, -1, t0);
    idle(20);
    check_eq("f55_nstart", start_q.size() - b_start, 1);
    check_eq("f55_start_cyc", q_at(start_q, b_start), t0 + 3);
    check_eq("f55_nstrobe", strobe_cyc_q.size() - b_strobe, NB);
    check_frame("f55", b_strobe, t0, 11'h4AA);
    check_eq("f55_nferr", ferr_q.size() - b_ferr, 0);
    check_eq("f55_busy_fall", q_at(busy_fall_q, b_fall), t0 + 2 + 169);
    check_eq("f55_state", dbg_state, 0);

    // 5-cycle low glitch
    mark();
    t0 = cyc;
    serial_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    check_eq("gl_nstart", start_q.size() - b_start, 1);
    check_eq("gl_abort_cyc", q_at(abort_q, b_abort), t0 + 2 + 8);
    check_eq("gl_nabort", abort_q.size() - b_abort, 1);
    check_eq("gl_nstrobe", strobe_cyc_q.size() - b_strobe, 0);
    check_eq("gl_busy", frame_busy, 0);
    check_eq("gl_state", dbg_state, 0);

    // Stop bit 0, then line held low (break), then a fresh frame 0x0F
    mark();
    send_frame(11'h078, -1, -1, t0);
    repeat (40) @(negedge clk);
    check_eq("brk_ferr_cyc", q_at(ferr_q, b_ferr), t0 + 2 + 168);
    check_eq("brk_last_strobe", q_at(strobe_cyc_q, b_strobe + NB - 1), t0 + 2 + 168);
    check_eq("brk_nstart_low", start_q.size() - b_start, 1);
    idle(20);
    send_frame(11'h41E, -1, -1, t1);
    idle(20);
    check_eq("brk_nstart", start_q.size() - b_start, 2);
    check_eq("brk_start2_cyc", q_at(start_q, b_start + 1), t1 + 3);
    check_frame("brk_f0f", b_strobe + NB, t1, 11'h41E);
    check_eq("brk_nferr", ferr_q.size() - b_ferr, 1);

    // Back-to-back 0xA3 then 0x0F
    mark();
    send_frame(11'h546, -1, -1, t0);
    send_frame(11'h41E, -1, -1, t1);
    idle(20);
    check_eq("b2b_nstrobe", strobe_cyc_q.size() - b_strobe, 2 * NB);
    check_eq("b2b_start1", q_at(start_q, b_start), t0 + 3);
    check_eq("b2b_start2", q_at(start_q, b_start + 1), t0 + 3 + NB * CPB);
    check_frame("b2b_a3", b_strobe, t0, 11'h546);
    check_frame("b2b_0f", b_strobe + NB, t0 + NB * CPB, 11'h41E);
    check_eq("b2b_nferr", ferr_q.size() - b_ferr, 0);

    // Enable dropped at cycle 50; rest of frame edges must be ignored
    mark();
    send_frame(11'h4AA, 50, -1, t0);
    idle(20);
    check_eq("en_abort_cyc", q_at(abort_q, b_abort), t0 + 2 + 50);
    check_eq("en_nabort", abort_q.size() - b_abort, 1);
    check_eq("en_nstrobe", strobe_cyc_q.size() - b_strobe, 3);
    check_eq("en_nstart", start_q.size() - b_start, 1);
    check_eq("en_busy_fall", q_at(busy_fall_q, b_fall), t0 + 2 + 50);
    check_eq("en_state", dbg_state, 0);
    enable = 1'b1;
    idle(20);

    // Reset mid-frame at cycle 70 with frame 0xA3
    mark();
    send_frame(11'h546, -1, 70, t0);
    #1;
    check_eq("mr_nstrobe_pre", strobe_cyc_q.size() - b_strobe, 4);
    check_eq("mr_sbit_pre", {31'd0, strobe_bit_q[strobe_bit_q.size() - 1]}, 0);
    check_eq("mr_busy_async", frame_busy, 0);
    check_eq("mr_sbit_async", sampled_bit, 1);
    check_eq("mr_state_async", dbg_state, 0);
    check_eq("mr_strobe_async", sampling_strobe, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(30);
    check_eq("mr_nabort", abort_q.size() - b_abort, 0);
    mark();
    send_frame(11'h4AA, -1, -1, t0);
    idle(20);
    check_eq("mr_nstart", start_q.size() - b_start, 1);
    check_eq("mr_start_cyc", q_at(start_q, b_start), t0 + 3);
    check_eq("mr_nstrobe", strobe_cyc_q.size() - b_strobe, NB);
    check_frame("mr_f55", b_strobe, t0, 11'h4AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_sample_ctrl.md
# rx_sample_ctrl

Sampling controller for the UART receiver: it synchronises the raw serial line, detects and qualifies the start-bit falling edge, and drives the `start_detected` / `sampling_strobe` inputs of the Rx state machine at the centre of every bit period. It also flags false starts (`rx_abort`) and bad stop bits (`framing_error`). It sits between the pad input and the Rx FSM/shift-register datapath.

## Interface
- `INPUT_DATA_WIDTH`, default 8: data bits per frame. Frame length is `NUMBER_OF_BITS = INPUT_DATA_WIDTH + 3` (start, data, parity, stop).
- `CLOCKS_PER_BIT`, default 16: clk cycles per bit period. Must be at least 4.
- `HALF_BIT`, derived as `CLOCKS_PER_BIT/2` (floor). Local parameter, not overridable.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  raw, asynchronous Rx line. Idle level is 1.
- `enable`  in  1  receiver enable.
- `start_detected`  out  1  one-cycle pulse on a qualified falling edge while IDLE.
- `sampling_strobe`  out  1  one-cycle pulse at each bit centre; `NUMBER_OF_BITS` pulses per good frame.
- `sampled_bit`  out  1  synchronised line value captured with each strobe; held between strobes.
- `rx_abort`  out  1  one-cycle pulse on a false start or on enable loss mid-frame. The top level ORs it into the Rx FSM reset.
- `framing_error`  out  1  one-cycle pulse when the stop-bit sample is 0.
- `frame_busy`  out  1  high from `start_detected` through the final strobe.

## Operation
- Synchroniser: two flops feed `line_s`. A third flop holds `line_d` (the previous `line_s`). Falling edge is `line_d & ~line_s`. All three flops reset to 1.
- State machine, three states:
  - **IDLE**: the tick counter is held at 0.
    - On a falling edge with `enable` high, go to START_VERIFY, pulse `start_detected`, raise `frame_busy`, and load the tick counter.
  - **START_VERIFY**: count to `HALF_BIT`, then sample `line_s`.
    - If 0, pulse `sampling_strobe`, set `bit_cnt` = 1, go to FRAME.
    - If 1, it was a glitch: pulse `rx_abort` (no strobe), drop `frame_busy`, go to IDLE.
  - **FRAME**: strobe every `CLOCKS_PER_BIT` cycles and increment `bit_cnt`.
    - On the strobe where `bit_cnt` = `NUMBER_OF_BITS-1` (the stop bit), also pulse `framing_error` if `line_s` = 0.
    - Then drop `frame_busy` and go to IDLE.
- `sampled_bit` is updated only on strobe cycles.
- `enable` low:
  - IDLE ignores edges.
  - START_VERIFY or FRAME: pulse `rx_abort`, go to IDLE. No strobe is issued on that cycle.
- Line held low after a frame (break) does not retrigger. A new start requires `line_s` to return to 1 and then fall again.
- Widths: the tick counter is `$clog2(CLOCKS_PER_BIT)` bits; `bit_cnt` is `$clog2(NUMBER_OF_BITS)` bits. Neither counter wraps; both reload explicitly.

## Timing
- Cycle 0 is the clock edge where the edge condition is first true. Latency from a `serial_in` fall to cycle 0 is 2–3 clocks (synchroniser).
- `start_detected` and `frame_busy` rise in cycle 1.
- Strobe k (k = 0..`NUMBER_OF_BITS-1`) occurs in cycle `HALF_BIT + k*CLOCKS_PER_BIT`.
  - For the defaults: cycles 8, 24, …, 168.
- `framing_error` is coincident with the last strobe. `frame_busy` falls in the cycle after it.
- A falling edge in the cycle right after the return to IDLE is accepted. Back-to-back frames need no idle gap beyond the stop bit.
- `rx_abort` is coincident with the verify point (cycle `HALF_BIT`) or with the first `enable`-low cycle.
- Reset (asynchronous, any state):
  - State goes to IDLE; counters go to 0.
  - All outputs go to 0 except `sampled_bit`, which resets to 1.
  - The synchroniser flops go to 1.
  - Mid-frame reset produces no `rx_abort`.
- All outputs are registered. No combinational path from `serial_in` to any output.

## Structure
- Shared package `uart_pkg` holds:
  - `NUMBER_OF_BITS` derivation;
  - Rx state encodings;
  - this block's state localparams: IDLE = 2'd0, START_VERIFY = 2'd1, FRAME = 2'd2.
- One sub-module, `rx_sync`: the two-flop synchroniser plus the delay flop and falling-edge output, reset to 1.
- Counters and the FSM live in `rx_sample_ctrl`.

## Test plan
Defaults throughout: `CLOCKS_PER_BIT` = 16, 8 data bits.

- Frame 0x55, even parity, stop = 1, `enable` = 1:
  - `start_detected` in cycle 1;
  - 11 strobes at cycles 8 + 16k;
  - `sampled_bit` sequence 0,1,0,1,0,1,0,1,0,0,1;
  - no `framing_error`; `frame_busy` falls in cycle 169.
- 5-cycle low glitch on `serial_in`: `start_detected`, then `rx_abort` in cycle 8; zero strobes; return to IDLE.
- Frame with stop bit = 0: `framing_error` coincides with the 11th strobe (cycle 168). Line held low afterwards produces no new `start_detected` until the line goes high and falls again.
- Two back-to-back frames, 0xA3 then 0x0F, with no idle gap: 22 strobes; the second `start_detected` is exactly 1 bit period after the first frame's stop-bit start.
- `enable` dropped at cycle 50 of a frame: `rx_abort` in that cycle; no further strobes; edges ignored while `enable` = 0.
- Reset asserted mid-frame at cycle 70:
  - outputs go to 0 immediately (asynchronously), `sampled_bit` to 1, no `rx_abort`;
  - after release, the next valid frame is received normally.
